if_fetch_stage: RTL and testbench

Instruction fetch stage, directly upstream of the IF/ID pipeline register. It holds the fetch PC and issues word reads to instruction memory over a single-outstanding request/valid handshake. Returned words go into a 2-entry prefetch buffer, which feeds the if_id bundle (we, pc_in, instr). Decode hazards stall the block, and taken branches/jumps from execute redirect it.

---
 rtl/if_fetch_stage.sv | 124 ++++++++++++
 tb/tb_if_fetch_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// if_fetch_stage : instruction fetch with a single-outstanding imem read and a
//                  2-entry prefetch buffer feeding the IF/ID register.
// Revision       : 1.0
// ============================================================================
module if_fetch_stage #(
    parameter int              PC_W     = 14,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_id_we,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr
);

    // Encoding is {outstanding, squash}
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WAIT  = 2'b10;
    localparam logic [1:0] ST_DRAIN = 2'b11;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    tag_pc;
    logic [PC_W-1:0]    hold_pc;
    logic [INSTR_W-1:0] hold_instr;
    logic [PC_W-1:0]    buf_pc    [2];
    logic [INSTR_W-1:0] buf_instr [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         count;
    logic               issue;
    logic               push;
    logic               pop;
    logic               not_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (issue) state_nxt = ST_WAIT;
            // A response landing in the redirect cycle is simply dropped
            ST_WAIT: begin
                if (imem_valid)    state_nxt = ST_IDLE;
                else if (redirect) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (imem_valid) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        not_empty   = (count != 2'd0);
        issue       = (state == ST_IDLE) && (count != 2'd2) && !redirect;
        push        = (state == ST_WAIT) && imem_valid && !redirect;
        pop         = not_empty && !stall && !redirect;
        imem_req    = issue && rst_n;
        imem_addr   = fetch_pc;
        if_id_we    = pop;
        if_id_pc    = not_empty ? buf_pc[rd_ptr]    : hold_pc;
        if_id_instr = not_empty ? buf_instr[rd_ptr] : hold_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            tag_pc     <= '0;
            hold_pc    <= '0;
            hold_instr <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_pc[i]    <= '0;
                buf_instr[i] <= '0;
            end
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            if (issue) begin
                tag_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + PC_W'(1);
            end
            if (push) begin
                buf_pc[wr_ptr]    <= tag_pc;
                buf_instr[wr_ptr] <= imem_rdata;
                wr_ptr            <= ~wr_ptr;
            end
            // Keep the departing head so outputs stay stable once empty
            if (pop) begin
                hold_pc    <= buf_pc[rd_ptr];
                hold_instr <= buf_instr[rd_ptr];
                rd_ptr     <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// Directed bench for if_fetch_stage: streaming, stall, redirect, wrap, reset.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [13:0] redirect_pc = '0;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        imem_req;
    logic [13:0] imem_addr;
    logic        if_id_we;
    logic [13:0] if_id_pc;
    logic [15:0] if_id_instr;

    logic        w_req;
    logic [13:0] w_addr;
    logic        w_valid = 1'b0;
    logic [13:0] w_addr_q = '0;
    logic [15:0] w_rdata;
    logic        w_we;
    logic [13:0] w_pc;
    logic [15:0] w_instr;

    int          nvec = 0;
    int          nerr = 0;
    int          lat = 1;
    bit          mem_en = 1'b1;
    logic [13:0] resp_addr;
    logic [13:0] reqq[$];
    logic [29:0] presq[$];
    logic [13:0] wreqq[$];
    logic [29:0] wpresq[$];

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [13:0] a);
        return {2'b10, a};
    endfunction

    if_fetch_stage #(.PC_W(14), .INSTR_W(16), .RESET_PC(14'h0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .if_id_we(if_id_we),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
    );

    if_fetch_stage #(.PC_W(14), .INSTR_W(16), .RESET_PC(14'h3FFE)) u_wrap (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(w_req), .imem_addr(w_addr),
        .imem_valid(w_valid), .imem_rdata(w_rdata), .if_id_we(w_we),
        .if_id_pc(w_pc), .if_id_instr(w_instr)
    );

    // Fixed 1-cycle memory for the wrap instance
    always @(posedge clk) begin
        w_valid  <= w_req;
        w_addr_q <= w_addr;
    end
    assign w_rdata = mem_word(w_addr_q);

    // Variable-latency memory for the main instance
    always begin
        @(negedge clk);
        if (rst_n && mem_en && imem_req) begin
            resp_addr = imem_addr;
            @(posedge clk);
            repeat (lat - 1) @(posedge clk);
            #1;
            imem_valid = 1'b1;
            imem_rdata = mem_word(resp_addr);
            @(posedge clk);
            #1;
            imem_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req) reqq.push_back(imem_addr);
            if (if_id_we) presq.push_back({if_id_pc, if_id_instr});
            if (w_req)    wreqq.push_back(w_addr);
            if (w_we)     wpresq.push_back({w_pc, w_instr});
        end
    end

    task automatic clear_logs;
        reqq.delete();
        presq.delete();
        wreqq.delete();
        wpresq.delete();
    endtask

    // Let any in-flight traffic settle, then reset and release with given stall
    task automatic do_reset(input bit st, input bit men);
        stall    = 1'b1;
        redirect = 1'b0;
        mem_en   = men;
        repeat (12) @(posedge clk);
        #1;
        rst_n      = 1'b0;
        imem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        stall = st;
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset;
        @(negedge clk);
        nvec++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        nvec++; if (if_id_we !== 1'b0) begin nerr++; $display("FAIL reset_we got=%b exp=0", if_id_we); end
        nvec++; if (if_id_pc !== 14'h0) begin nerr++; $display("FAIL reset_pc got=%h exp=0", if_id_pc); end
        nvec++; if (if_id_instr !== 16'h0) begin nerr++; $display("FAIL reset_instr got=%h exp=0", if_id_instr); end
        nvec++; if (w_pc !== 14'h0) begin nerr++; $display("FAIL reset_wrap_pc got=%h exp=0", w_pc); end
    endtask

    task automatic test_stream;
        lat = 1;
        do_reset(1'b0, 1'b1);
        repeat (24) @(posedge clk);
        #1;
        nvec++; if (reqq.size() < 6 || presq.size() < 6) begin
            nerr++; $display("FAIL stream_count reqs=%0d pres=%0d exp>=6", reqq.size(), presq.size());
        end
        for (int i = 0; i < 6; i++) begin
            nvec++; if (reqq[i] !== 14'(i)) begin
                nerr++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, reqq[i], 14'(i));
            end
            nvec++; if (presq[i] !== {14'(i), mem_word(14'(i))}) begin
                nerr++; $display("FAIL stream_pres[%0d] got=%h exp=%h", i, presq[i], {14'(i), mem_word(14'(i))});
            end
        end
    endtask

    task automatic test_stall;
        lat = 1;
        do_reset(1'b1, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        nvec++; if (reqq.size() != 2) begin nerr++; $display("FAIL stall_nreq got=%0d exp=2", reqq.size()); end
        nvec++; if (reqq[0] !== 14'h0 || reqq[1] !== 14'h1) begin
            nerr++; $display("FAIL stall_addrs got=%h,%h exp=0,1", reqq[0], reqq[1]);
        end
        nvec++; if (presq.size() != 0) begin nerr++; $display("FAIL stall_held pres=%0d exp=0", presq.size()); end
        nvec++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL stall_full_req got=%b exp=0", imem_req); end
        stall = 1'b0;
        @(negedge clk);
        nvec++; if (if_id_we !== 1'b1 || if_id_pc !== 14'h0 || if_id_instr !== 16'h8000) begin
            nerr++; $display("FAIL stall_pop0 we=%b pc=%h instr=%h exp 1/0000/8000", if_id_we, if_id_pc, if_id_instr);
        end
        @(negedge clk);
        nvec++; if (if_id_we !== 1'b1 || if_id_pc !== 14'h1 || if_id_instr !== 16'h8001) begin
            nerr++; $display("FAIL stall_pop1 we=%b pc=%h instr=%h exp 1/0001/8001", if_id_we, if_id_pc, if_id_instr);
        end
        repeat (4) @(posedge clk);
        #1;
        nvec++; if (reqq[2] !== 14'h2) begin nerr++; $display("FAIL stall_resume got=%h exp=0002", reqq[2]); end
    endtask

    task automatic test_redirect_drain;
        bit found;
        bit saw5;
        lat   = 4;
        found = 1'b0;
        saw5  = 1'b0;
        do_reset(1'b0, 1'b1);
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 14'h5) found = 1'b1;
        end
        nvec++; if (!found) begin nerr++; $display("FAIL drain_timeout got=none exp=req 0005"); end
        @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = 14'h0100;
        clear_logs();
        @(negedge clk);
        nvec++; if (if_id_we !== 1'b0 || imem_req !== 1'b0) begin
            nerr++; $display("FAIL drain_redir_cycle we=%b req=%b exp=0/0", if_id_we, imem_req);
        end
        @(posedge clk);
        #1;
        redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nvec++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL drain_wait[%0d] req=%b exp=0", k, imem_req); end
        end
        @(negedge clk);
        nvec++; if (imem_req !== 1'b1 || imem_addr !== 14'h0100) begin
            nerr++; $display("FAIL drain_refetch req=%b addr=%h exp=1/0100", imem_req, imem_addr);
        end
        repeat (12) @(posedge clk);
        #1;
        foreach (presq[i]) if (presq[i][29:16] == 14'h5) saw5 = 1'b1;
        nvec++; if (saw5) begin nerr++; $display("FAIL drain_squash got=pc 0005 presented exp=absent"); end
        nvec++; if (presq.size() == 0 || presq[0] !== {14'h0100, 16'h8100}) begin
            nerr++; $display("FAIL drain_first n=%0d got=%h exp=%h", presq.size(), presq[0], {14'h0100, 16'h8100});
        end
    endtask

    task automatic test_redirect_full;
        lat = 1;
        do_reset(1'b1, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        nvec++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL full_req got=%b exp=0", imem_req); end
        redirect    = 1'b1;
        redirect_pc = 14'h0100;
        imem_valid  = 1'b1;
        imem_rdata  = 16'hDEAD;
        clear_logs();
        @(negedge clk);
        nvec++; if (if_id_we !== 1'b0 || imem_req !== 1'b0) begin
            nerr++; $display("FAIL full_redir_cycle we=%b req=%b exp=0/0", if_id_we, imem_req);
        end
        @(posedge clk);
        #1;
        redirect   = 1'b0;
        imem_valid = 1'b0;
        stall      = 1'b0;
        @(negedge clk);
        nvec++; if (if_id_we !== 1'b0) begin nerr++; $display("FAIL full_flushed we=%b exp=0", if_id_we); end
        nvec++; if (imem_req !== 1'b1 || imem_addr !== 14'h0100) begin
            nerr++; $display("FAIL full_refetch req=%b addr=%h exp=1/0100", imem_req, imem_addr);
        end
        repeat (6) @(posedge clk);
        #1;
        nvec++; if (presq.size() == 0 || presq[0] !== {14'h0100, 16'h8100}) begin
            nerr++; $display("FAIL full_first n=%0d got=%h exp=%h", presq.size(), presq[0], {14'h0100, 16'h8100});
        end
    endtask

    task automatic test_wrap;
        logic [13:0] exp_a [3];
        exp_a[0] = 14'h3FFE;
        exp_a[1] = 14'h3FFF;
        exp_a[2] = 14'h0000;
        do_reset(1'b0, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        nvec++; if (wreqq.size() < 3 || wpresq.size() < 3) begin
            nerr++; $display("FAIL wrap_count reqs=%0d pres=%0d exp>=3", wreqq.size(), wpresq.size());
        end
        for (int i = 0; i < 3; i++) begin
            nvec++; if (wreqq[i] !== exp_a[i]) begin
                nerr++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, wreqq[i], exp_a[i]);
            end
            nvec++; if (wpresq[i] !== {exp_a[i], mem_word(exp_a[i])}) begin
                nerr++; $display("FAIL wrap_pres[%0d] got=%h exp=%h", i, wpresq[i], {exp_a[i], mem_word(exp_a[i])});
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset(1'b0, 1'b0);
        @(negedge clk);
        nvec++; if (imem_req !== 1'b1 || imem_addr !== 14'h0) begin
            nerr++; $display("FAIL rmid_first req=%b addr=%h exp=1/0000", imem_req, imem_addr);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        nvec++; if (imem_req !== 1'b0 || if_id_we !== 1'b0) begin
            nerr++; $display("FAIL rmid_in_reset req=%b we=%b exp=0/0", imem_req, if_id_we);
        end
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 16'hBEEF;
        clear_logs();
        @(negedge clk);
        nvec++; if (imem_req !== 1'b1 || imem_addr !== 14'h0) begin
            nerr++; $display("FAIL rmid_restart req=%b addr=%h exp=1/0000", imem_req, imem_addr);
        end
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (presq.size() != 0) begin nerr++; $display("FAIL rmid_stale pres=%0d exp=0", presq.size()); end
        imem_valid = 1'b1;
        imem_rdata = 16'h8000;
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        @(negedge clk);
        nvec++; if (if_id_we !== 1'b1 || if_id_pc !== 14'h0 || if_id_instr !== 16'h8000) begin
            nerr++; $display("FAIL rmid_word we=%b pc=%h instr=%h exp 1/0000/8000", if_id_we, if_id_pc, if_id_instr);
        end
        mem_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drain();
        test_redirect_full();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
